// File: rtl/tone_player.sv
// tone_player: note request consumer driving the half-period ROM
// and a square-wave speaker output with a trailing silent gap.
module tone_player #(
  parameter int MS_TICKS = 50000,
  parameter int DUR_W    = 16,
  parameter int GAP_MS   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note_index,
  input  logic [DUR_W-1:0] note_dur_ms,
  input  logic             stop,
  output logic [3:0]       rom_address,
  input  logic [31:0]      rom_data,
  output logic             speaker,
  output logic             playing,
  output logic             done_pulse
);

  localparam int MSW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [MSW-1:0] MS_LAST = MSW'(MS_TICKS - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_MS * MS_TICKS - 1);
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       addr_q, addr_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [31:0]      half_q, half_d;
  logic [31:0]      phase_q, phase_d;
  logic [MSW-1:0]   ms_q, ms_d;
  logic [31:0]      gap_q, gap_d;
  logic             spk_q, spk_d;
  logic             done_q, done_d;

  // Next-state logic: handshake, ROM latch, tone timing, gap, abort
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dur_d   = dur_q;
    half_d  = half_q;
    phase_d = phase_q;
    ms_d    = ms_q;
    gap_d   = gap_q;
    spk_d   = spk_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (note_valid) begin
          addr_d  = note_index;
          dur_d   = note_dur_ms;
          state_d = LOAD;
        end
      end
      LOAD: begin
        half_d  = rom_data;
        phase_d = '0;
        ms_d    = '0;
        gap_d   = '0;
        spk_d   = 1'b0;
        if (dur_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = TONE;
        end
      end
      TONE: begin
        if (half_q != '0) begin
          if (phase_q == half_q - 32'd1) begin
            phase_d = '0;
            spk_d   = ~spk_q;
          end else begin
            phase_d = phase_q + 32'd1;
          end
        end else begin
          spk_d = 1'b0;
        end
        if (ms_q == MS_LAST) begin
          ms_d = '0;
          if (dur_q != '0) begin
            dur_d = dur_q - DUR_ONE;
          end
          if (dur_q <= DUR_ONE) begin
            spk_d   = 1'b0;
            phase_d = '0;
            gap_d   = '0;
            if (GAP_MS == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end
        end else begin
          ms_d = ms_q + MSW'(1);
        end
      end
      GAP: begin
        spk_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      spk_d   = 1'b0;
      done_d  = 1'b0;
      dur_d   = '0;
      phase_d = '0;
      ms_d    = '0;
      gap_d   = '0;
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dur_q   <= '0;
      half_q  <= '0;
      phase_q <= '0;
      ms_q    <= '0;
      gap_q   <= '0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      ms_q    <= ms_d;
      gap_q   <= gap_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
    end
  end

  assign note_ready  = (state_q == IDLE) && !reset;
  assign playing     = (state_q != IDLE);
  assign rom_address = addr_q;
  assign speaker     = spk_q;
  assign done_pulse  = done_q;

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed checks of tone_player timing with
// MS_TICKS=10 and GAP_MS=1 against a small ROM stub.
module tb_tone_player;

  logic        clk;
  logic        reset;
  logic        note_valid;
  logic        note_ready;
  logic [3:0]  note_index;
  logic [15:0] note_dur_ms;
  logic        stop;
  logic [3:0]  rom_address;
  logic [31:0] rom_data;
  logic        speaker;
  logic        playing;
  logic        done_pulse;

  int checks = 0;
  int errors = 0;

  int n_play, n_tog, n_high, n_done, done_off, high_off, n_rdy;

  tone_player #(.MS_TICKS(10), .DUR_W(16), .GAP_MS(1)) dut (
    .clk(clk),
    .reset(reset),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_index(note_index),
    .note_dur_ms(note_dur_ms),
    .stop(stop),
    .rom_address(rom_address),
    .rom_data(rom_data),
    .speaker(speaker),
    .playing(playing),
    .done_pulse(done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM stub: index 4 -> 5, index 2 -> 4, everything else is a rest
  always_comb begin
    rom_data = 32'd0;
    case (rom_address)
      4'd4: rom_data = 32'd5;
      4'd2: rom_data = 32'd4;
      default: rom_data = 32'd0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic observe(input int n);
    logic prev;
    n_play = 0; n_tog = 0; n_high = 0; n_done = 0;
    done_off = -1; high_off = -1; n_rdy = 0;
    prev = speaker;
    for (int i = 0; i < n; i++) begin
      if (playing) n_play++;
      if (speaker !== prev) n_tog++;
      prev = speaker;
      if (speaker) begin
        n_high++;
        if (high_off < 0) high_off = i;
      end
      if (done_pulse) begin
        n_done++;
        if (done_off < 0) done_off = i;
      end
      if (playing && note_ready) n_rdy++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    note_valid = 1'b1;
    note_index = 4'd4;
    note_dur_ms = 16'd3;
    stop = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_speaker", int'(speaker), 0);
      chk("rst_playing", int'(playing), 0);
      chk("rst_done", int'(done_pulse), 0);
      chk("rst_ready", int'(note_ready), 0);
    end
    chk("rst_addr", int'(rom_address), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", int'(note_ready), 1);

    step();
    note_valid = 1'b0;
    chk("t2_addr", int'(rom_address), 4);
    chk("t2_ready_load", int'(note_ready), 0);
    observe(45);
    chk("t2_play", n_play, 41);
    chk("t2_toggles", n_tog, 6);
    chk("t2_high", n_high, 15);
    chk("t2_first_high", high_off, 6);
    chk("t2_done_cnt", n_done, 1);
    chk("t2_done_off", done_off, 41);
    chk("t2_ready_busy", n_rdy, 0);

    note_valid = 1'b1;
    note_index = 4'd7;
    note_dur_ms = 16'd2;
    step();
    note_valid = 1'b0;
    observe(35);
    chk("t3_play", n_play, 31);
    chk("t3_toggles", n_tog, 0);
    chk("t3_high", n_high, 0);
    chk("t3_done_cnt", n_done, 1);
    chk("t3_done_off", done_off, 31);

    note_valid = 1'b1;
    note_index = 4'd4;
    note_dur_ms = 16'd0;
    step();
    note_valid = 1'b0;
    observe(4);
    chk("t4_play", n_play, 1);
    chk("t4_toggles", n_tog, 0);
    chk("t4_done_cnt", n_done, 1);
    chk("t4_done_off", done_off, 1);

    note_valid = 1'b1;
    note_index = 4'd2;
    note_dur_ms = 16'd5;
    step();
    note_valid = 1'b0;
    repeat (13) step();
    chk("t5_spk_before", int'(speaker), 1);
    chk("t5_play_before", int'(playing), 1);
    stop = 1'b1;
    step();
    chk("t5_spk_after", int'(speaker), 0);
    chk("t5_play_after", int'(playing), 0);
    chk("t5_ready_after", int'(note_ready), 1);
    chk("t5_no_done", int'(done_pulse), 0);
    note_valid = 1'b1;
    note_index = 4'd4;
    note_dur_ms = 16'd0;
    step();
    stop = 1'b0;
    note_valid = 1'b0;
    chk("t5_reaccept", int'(playing), 1);
    chk("t5_addr", int'(rom_address), 4);
    chk("t5_no_done2", int'(done_pulse), 0);
    step();
    chk("t5_done_new", int'(done_pulse), 1);

    note_valid = 1'b1;
    note_index = 4'd4;
    note_dur_ms = 16'd1;
    step();
    for (int k = 0; k < 21; k++) begin
      chk("t6_ready_busy", int'(note_ready), 0);
      chk("t6_addr_hold", int'(rom_address), 4);
      note_index = 4'(k + 5);
      step();
    end
    chk("t6_done", int'(done_pulse), 1);
    chk("t6_ready_done", int'(note_ready), 1);
    note_index = 4'd2;
    note_dur_ms = 16'd1;
    step();
    note_valid = 1'b0;
    chk("t6_addr_new", int'(rom_address), 2);
    chk("t6_play_new", int'(playing), 1);
    observe(25);
    chk("t6_play", n_play, 21);
    chk("t6_high", n_high, 4);
    chk("t6_done_cnt", n_done, 1);
    chk("t6_done_off", done_off, 21);

    note_valid = 1'b1;
    note_index = 4'd4;
    note_dur_ms = 16'd3;
    step();
    note_valid = 1'b0;
    repeat (8) step();
    chk("t7_spk_mid", int'(speaker), 1);
    reset = 1'b1;
    step();
    chk("t7_spk", int'(speaker), 0);
    chk("t7_play", int'(playing), 0);
    chk("t7_addr", int'(rom_address), 0);
    chk("t7_done", int'(done_pulse), 0);
    chk("t7_ready_rst", int'(note_ready), 0);
    reset = 1'b0;
    #1;
    chk("t7_ready", int'(note_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Consumer end of the note-to-half-period ROM interface.
- Accepts note requests (note index plus duration in ms) over a valid/ready handshake and drives the 4-bit note address to the ROM.
- Latches the returned 32-bit half-period count and generates a square wave on the speaker pin for the requested duration, followed by a fixed silent gap.
- Sits between the melody/game sequencer and the board speaker/buzzer pin.

Parameters:
- MS_TICKS, 50000, clock cycles per millisecond (50 MHz clock); benches use 10.
- DUR_W, 16, width of the duration field in ms.
- GAP_MS, 10, silent gap after each note in ms; 0 means no gap.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- note_valid  in  1  request valid.
- note_ready  out  1  block can accept a request.
- note_index  in  4  note code presented to the ROM.
- note_dur_ms  in  DUR_W  note duration in ms.
- stop  in  1  synchronous abort of the current note.
- rom_address  out  4  address to the note ROM.
- rom_data  in  32  half-period count from the ROM (combinational, same cycle); 0 means rest.
- speaker  out  1  square-wave output.
- playing  out  1  high whenever state != IDLE.
- done_pulse  out  1  one-cycle pulse at normal note completion.

Behaviour:
- Reset values: state IDLE, rom_address 0, speaker 0, done_pulse 0, all counters 0, latched duration 0, latched half period 0.
- note_ready = (state==IDLE) && !reset. It is therefore 1 in the first cycle after reset is released.
- playing = (state!=IDLE).
- FSM states: IDLE, LOAD, TONE, GAP.
- IDLE:
  - On note_valid && note_ready, latch note_index into rom_address and note_dur_ms into dur_cnt, then go to LOAD.
  - Inputs are ignored outside the accepting cycle.
- LOAD (exactly 1 cycle):
  - Latch half_per = rom_data.
  - If dur_cnt==0: go to IDLE and assert done_pulse in the next cycle. Speaker never toggles.
  - Otherwise: clear phase_cnt and ms_cnt, speaker=0, go to TONE.
- TONE:
  - half_per != 0: phase_cnt increments each cycle. When phase_cnt==half_per-1, speaker toggles and phase_cnt clears. The first toggle occurs half_per cycles after TONE entry; half_per==1 toggles every cycle.
  - half_per == 0 (rest): speaker held 0 for the full duration.
  - ms_cnt counts 0..MS_TICKS-1. At wrap, dur_cnt decrements.
  - When dur_cnt reaches 0: go to GAP, or to IDLE if GAP_MS==0.
  - TONE lasts exactly dur*MS_TICKS cycles.
- GAP:
  - speaker forced 0.
  - Counts GAP_MS*MS_TICKS cycles, then goes to IDLE.
- done_pulse is asserted for exactly one cycle: the first IDLE cycle after a normal finish.
- Arithmetic widths:
  - phase_cnt is 32 bits; half_per compares unsigned.
  - ms_cnt wide enough for MS_TICKS-1.
  - dur_cnt is DUR_W bits and never underflows.
- stop:
  - In any non-IDLE state, the next cycle is IDLE with speaker 0, no done_pulse, and counters cleared.
  - stop in IDLE has no effect.
  - If stop and note_valid arrive in the same IDLE cycle, the request is accepted.
- reset mid-note: same as stop; all outputs return to reset values next cycle.
- rom_address holds its value after the note ends, until the next accepted request.
- Back-to-back requests: a new request can be accepted in the cycle done_pulse is high.

Test Plan:
- Reset held 3 cycles with note_valid=1 -> speaker=0, playing=0, done_pulse=0, note_ready=0 during reset; note_ready=1 in the first cycle after release.
- (MS_TICKS=10, GAP_MS=1) index 4, ROM stub returns 5, dur 3 -> rom_address=4 one cycle after handshake; 30-cycle TONE with speaker toggling every 5 cycles (6 toggles, ends 0); 10-cycle gap with speaker=0; done_pulse a single cycle; playing high for 41 cycles.
- ROM stub returns 0 (rest), dur 2 -> speaker constant 0, playing high 1+20+10 cycles, done_pulse once.
- dur 0 -> LOAD only; playing high 1 cycle; done_pulse 2 cycles after handshake; no toggles.
- stop asserted 12 cycles into TONE -> next cycle speaker=0, playing=0, note_ready=1, no done_pulse; a new request is accepted immediately after.
- note_valid held high with changing note_index during play -> only the value at handshake is used; the second request is accepted in the done_pulse cycle; note_ready=0 throughout LOAD/TONE/GAP.
